// File: rtl/drum_pkg.sv
// drum_pkg: shared widths and helpers for the DRUM4 multiplier and its arbiter.
// Contents: operand/result widths, DRUM segment width K, clog2 for index widths.
package drum_pkg;
    localparam int DRUM_OP_W  = 16;
    localparam int DRUM_RES_W = 32;
    localparam int DRUM_K     = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/DRUM4_16_u.sv
// DRUM4_16_u: unsigned 16x16 DRUM approximate multiplier with a 4-bit segment.
// Ports: a, b - unsigned operands; r - approximate 32-bit product (combinational).
module DRUM4_16_u
    import drum_pkg::*;
(
    output logic [DRUM_RES_W-1:0] r,
    input  logic [DRUM_OP_W-1:0]  a,
    input  logic [DRUM_OP_W-1:0]  b
);
    localparam int LW = clog2(DRUM_OP_W);

    logic [LW-1:0]     pa, pb, sa, sb;
    logic [DRUM_K-1:0] ma, mb;

    // Operands below 2^K pass exactly; larger ones keep the K bits under the
    // leading one with the lowest kept bit forced high to centre the truncation error.
    always_comb begin
        pa = '0;
        pb = '0;
        for (int i = 0; i < DRUM_OP_W; i++) begin
            if (a[i]) pa = LW'(i);
            if (b[i]) pb = LW'(i);
        end
        sa = (pa >= LW'(DRUM_K)) ? pa - LW'(DRUM_K - 1) : '0;
        sb = (pb >= LW'(DRUM_K)) ? pb - LW'(DRUM_K - 1) : '0;
        ma = DRUM_K'(a >> sa) | DRUM_K'(pa >= LW'(DRUM_K));
        mb = DRUM_K'(b >> sb) | DRUM_K'(pb >= LW'(DRUM_K));
        r  = (DRUM_RES_W'(ma) * DRUM_RES_W'(mb)) << ({1'b0, sa} + {1'b0, sb});
    end
endmodule

// File: rtl/drum_rr_arbiter.sv
// drum_rr_arbiter: round-robin grant starting the search at ptr.
// Ports: req - request vector; ptr - search start; en - grant enable;
//        gnt - one-hot grant; idx - granted index; any - a grant was issued.
module drum_rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);
    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (en && !any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = ID_W'(j);
            end
        end
    end
endmodule

// File: rtl/drum_mul_arbiter.sv
// drum_mul_arbiter: shares one DRUM4_16_u among NUM_REQ requesters, round-robin, 2-stage pipe.
// Ports: clk, rst (async, active-high); req_valid/req_ready/req_a/req_b - per-requester
//        operand handshake (16-bit slices); rsp_valid/rsp_ready/rsp_id/rsp_result - tagged
//        result channel; op_count - completed responses (wraps); busy - pipe occupied.
module drum_mul_arbiter
    import drum_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [DRUM_OP_W*NUM_REQ-1:0]   req_a,
    input  logic [DRUM_OP_W*NUM_REQ-1:0]   req_b,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [DRUM_RES_W-1:0]          rsp_result,
    output logic [CNT_W-1:0]               op_count,
    output logic                           busy
);
    logic                  s0_vld, s1_vld, adv0, adv1, take;
    logic [DRUM_OP_W-1:0]  a_reg, b_reg, sel_a, sel_b;
    logic [ID_W-1:0]       s0_id, rr_ptr, g_idx;
    logic [DRUM_RES_W-1:0] prod;

    assign adv1      = !s1_vld | rsp_ready;
    assign adv0      = !s0_vld | adv1;
    assign rsp_valid = s1_vld;
    assign busy      = s0_vld | s1_vld;
    assign sel_a     = req_a[int'(g_idx)*DRUM_OP_W +: DRUM_OP_W];
    assign sel_b     = req_b[int'(g_idx)*DRUM_OP_W +: DRUM_OP_W];

    // Grants are suppressed during reset so no requester sees a spurious accept.
    drum_rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .en  (adv0 & !rst),
        .gnt (req_ready),
        .idx (g_idx),
        .any (take)
    );

    DRUM4_16_u u_mul (
        .r (prod),
        .a (a_reg),
        .b (b_reg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_vld     <= 1'b0;
            s1_vld     <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            s0_id      <= '0;
            rr_ptr     <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            op_count   <= '0;
        end else begin
            if (adv0) begin
                s0_vld <= take;
                if (take) begin
                    a_reg  <= sel_a;
                    b_reg  <= sel_b;
                    s0_id  <= g_idx;
                    rr_ptr <= (int'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + 1'b1;
                end
            end
            if (adv1) begin
                s1_vld <= s0_vld;
                if (s0_vld) begin
                    rsp_result <= prod;
                    rsp_id     <= s0_id;
                end
            end
            if (s1_vld && rsp_ready) op_count <= op_count + CNT_W'(1);
        end
    end
endmodule

// File: doc/drum_mul_arbiter.md
Name: drum_mul_arbiter

Overview:
- Shares one DRUM4_16_u approximate 16x16 multiplier among NUM_REQ requesters (CNN PE lanes) using round-robin arbitration.
- Each requester presents an operand pair with a valid/ready handshake.
- Results return on one response channel, tagged with the requester index, with backpressure.
- Sits between the PE operand buffers and the accumulators in the approximate CNN datapath.

Parameters:
- NUM_REQ, 4, number of requesters; legal values 2..8.
- ID_W, 2, width of the requester index; equals clog2(NUM_REQ).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  16*NUM_REQ  operand A; requester i uses bits [16i+15:16i].
- req_b  in  16*NUM_REQ  operand B; same packing as req_a.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_result  out  32  DRUM4 product.
- op_count  out  CNT_W  number of completed responses; wraps.
- busy  out  1  high while either pipeline stage holds data.

Behaviour:
- Reset (async assert, sync release): s0_vld=0, s1_vld=0, rr_ptr=0, op_count=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, req_ready=0.
- Pipeline, stage S0 (operand register): holds a_reg, b_reg, id.
- Pipeline, stage S1 (result register): holds DRUM4_16_u(r, a_reg, b_reg) and id. Stage S1 drives rsp_*.
- Stall rules:
  - adv1 = !s1_vld | rsp_ready.
  - adv0 = !s0_vld | adv1.
- Grant:
  - When adv0=1, the first requester with req_valid=1, searching from rr_ptr upward and wrapping modulo NUM_REQ, is granted.
  - req_ready[g] is asserted combinationally in that cycle. The handshake completes when req_valid[g] & req_ready[g].
  - When adv0=0, req_ready=0.
- rr_ptr update: on a grant, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Latency:
  - A handshake in cycle T gives rsp_valid in cycle T+2 when no stall occurs.
  - Throughput is one operation per cycle.
- Backpressure:
  - While rsp_valid & !rsp_ready, rsp_id and rsp_result hold stable.
  - S0 holds if occupied; at most 2 operations are in flight.
- S0 to S1 transfer: when s0_vld & adv1, S1 loads. If S0 is also re-granted in the same cycle, both stages update together with no bubble.
- S1 drain: on rsp_valid & rsp_ready with no incoming S0 data, s1_vld <= 0.
- op_count: increments on each rsp_valid & rsp_ready, and wraps from 2^CNT_W-1 to 0.
- busy = s0_vld | s1_vld.
- The arithmetic is exactly the DRUM4_16_u combinational output. The arbiter applies no rounding, sign handling or zero bypass; operands are unsigned.
- Simultaneous requests from all requesters: grants rotate 0,1,2,3,0 from reset.
- A requester that drops valid is skipped with no penalty.
- Reset mid-operation discards in-flight data immediately. No response is produced for discarded operands.
- req_valid must stay high until accepted. If it is withdrawn early, the operation is simply not taken, and the arbiter remains correct.

Decomposition:
- Shared package drum_pkg holds:
  - DRUM_OP_W = 16 and DRUM_RES_W = 32.
  - DRUM_K = 4.
  - A clog2 function for ID_W.
- Natural sub-module: drum_rr_arbiter, the round-robin grant logic (req vector, rr_ptr, enable -> one-hot grant, index).
- DRUM4_16_u is instantiated unchanged (ports r, a, b).

Test Plan:
- Reset, then only req 0 with A=0x0005, B=0x000A and rsp_ready=1 -> rsp_valid in cycle T+2, rsp_id=0, rsp_result=0x00000032, op_count=1.
- All 4 requesters valid continuously with A=0x000F, B=0x000F and rsp_ready=1 -> grants in order 0,1,2,3,0,1; one response per cycle, each 0x000000E1; ids in the same order.
- Backpressure: rsp_ready=0 for 5 cycles with all requesters valid -> exactly 2 operations accepted, then req_ready=0; rsp_id and rsp_result are stable throughout; on release, the responses drain in order.
- Operands A=0x0000, B=0xFFFF from req 2 -> rsp_result=0x00000000, rsp_id=2.
- Random operands (including 0xFFFF/0xFFFF, 0x5555/0xAAAA, 0xFF00/0x00FF) from random requesters -> every rsp_result matches a standalone DRUM4_16_u golden model and ids match issue order.
- Assert rst while 2 operations are in flight -> rsp_valid=0 and busy=0 immediately, no stale response after release, and the next grant goes to req 0; also preset op_count near 0xFFFF and check the wrap to 0.
